packetizer: RTL
===============

# packetizer

Transmit-side framer for the sequenced stream protocol. It accepts one payload of up to 37 bytes per handshake, together with a stream ID and a byte length. It emits the packet as 32-bit words: a header word with length and stream ID, a sequence word, then the payload words. A 32-entry per-stream sequence table lets the downstream parser see gap-free sequence numbers. It sits between the packet source and the 32-bit link, and its output format matches what `parser` consumes.

## Interface
- `NUM_STREAMS`, default 32: size of the sequence table; indexed by `stream_id[4:0]`.
- `MAX_PAYLOAD_BYTES`, default 37: largest legal `payload_len`.
- `clk`  in  1  sole clock; everything is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `payload_in`  in  [0:295]  payload, big-endian; byte k is bits [8k:8k+7].
- `payload_len`  in  6  payload byte count; legal range 1..37.
- `stream_id`  in  16  stream identifier.
- `payload_val`  in  1  source has a payload.
- `payload_ready`  out  1  block can accept a payload; reset value 1.
- `dataOut`  out  32  link word; 0 whenever `dataOut_val`=0; reset value 0.
- `dataOut_val`  out  1  link word valid; reset value 0.
- `dataOut_ready`  in  1  link accepts the word.
- `dataOut_last`  out  1  final word of the packet; reset value 0.
- `err_len`  out  1  one-cycle pulse when an illegal length is dropped; reset value 0.

## Operation
- Byte lanes within a word: byte 0 = [31:24], byte 3 = [7:0].
- Header word 0 = {L[7:0], L[15:8], sid[7:0], sid[15:8]}.
  - L = `payload_len` + 8, i.e. total packet bytes including both header words.
- Header word 1 = {seq[7:0], seq[15:8], seq[23:16], seq[31:24]}, little-endian.
- Data word i = `payload_in`[32i : 32i+31].
  - The final data word carries `payload_len`-4·(N-1) valid bytes, where N = ceil(`payload_len`/4).
  - Unused low bytes of the final word are zero.
- Packet length is 2+N words. `dataOut_last` is asserted only with the final data word.
- Sequence table: 32×32-bit entries, all 0 after reset.
  - On acceptance: seq = table[`stream_id`[4:0]] + 1, and the table entry is written with seq in the same cycle.
  - The first packet on a fresh stream therefore carries seq 1.
  - Stream IDs that differ only above bit 4 share one entry.
  - Increment wraps modulo 2^32 (0xFFFFFFFF is followed by 0).
- Payload, L, stream ID and seq are captured at acceptance. The inputs may change afterwards.
- Illegal length (`payload_len` = 0 or > 37):
  - The payload is still accepted (handshake completes).
  - `err_len` is high the following cycle.
  - No words are emitted, the table is unchanged, and the block stays in IDLE.
- States and transitions:
  - IDLE: `payload_ready`=1. On `payload_val` with a legal length, go to HDR0.
  - HDR0: on the link handshake, go to HDR1.
  - HDR1: on the link handshake, go to DATA with word index 0.
  - DATA: on the link handshake, increment the index. On the handshake of the last word, go to IDLE.
  - `payload_ready`=0 in every state other than IDLE.
  - Any unreachable encoding goes to IDLE.

## Timing
- Acceptance cycle: `payload_val` & `payload_ready`. Word 0 is valid on the next cycle.
- Link handshake: `dataOut_val` & `dataOut_ready`. Words advance only on a handshake.
- While `dataOut_val`=1 and `dataOut_ready`=0, `dataOut` and `dataOut_last` hold stable.
- `dataOut_val` stays high from HDR0 through the last handshake, with no bubbles.
- After the last handshake: `dataOut_val`=0 and `payload_ready`=1 on the next cycle.
- Minimum packet period is 2+N+1 cycles.
- `payload_ready` is registered; there is no combinational path from `dataOut_ready` to it.
- Reset mid-packet:
  - Outputs take their reset values on the next cycle.
  - The partial packet is abandoned.
  - The table is cleared to 0.

## Structure
- Shared package `parser_pkg` holds:
  - `MAX_PAYLOAD_BYTES` and `HDR_BYTES` = 8;
  - the state enum {IDLE, HDR0, HDR1, DATA};
  - byte-swap functions `pack_hdr0(len, sid)` and `pack_seq(seq)`, so they can be reused by `parser`.
- Sub-module `seq_table`:
  - 32×32 register file;
  - combinational read, plus a read+1 result;
  - synchronous write and synchronous clear on `reset`.
- Top level holds the FSM, the payload capture register, the word index, and the last-word masking.

## Test plan
- Reset, then stream 0x0005, len 5, bytes 11..15 -> 0x0D000500, 0x01000000, 0x11121314, 0x15000000 with last on word 4.
- Second packet on 0x0005, then one on 0x0025 -> seq words 0x02000000 and 0x03000000 (shared entry). A packet on 0x0006 -> 0x01000000.
- len 37 -> 12 words, last word 0xBB000000 for byte 36 = BB. len 4 -> 3 words, last word fully populated.
- `dataOut_ready` low for 3 cycles on word 2 -> word and last held constant, no word lost or duplicated, `payload_ready` stays 0.
- len 0 and len 38 -> `err_len` one-cycle pulse, `dataOut_val` stays 0. The next legal packet on that stream continues the sequence unchanged.
- `reset` asserted after the HDR1 handshake -> next cycle `dataOut_val`=0 and `payload_ready`=1. The next packet on the same stream carries seq 1.

Source files
------------

// File: rtl/parser_pkg.sv
// rtl/parser_pkg.sv - shared framing constants, FSM states and header byte-swap helpers
package parser_pkg;

  localparam int MAX_PAYLOAD_BYTES = 37;
  localparam int HDR_BYTES         = 8;

  typedef enum logic [1:0] {IDLE, HDR0, HDR1, DATA} state_t;

  // Header word 0: total length then stream ID, each 16-bit field little-endian on the link.
  function automatic logic [31:0] pack_hdr0(input logic [15:0] len, input logic [15:0] sid);
    return {len[7:0], len[15:8], sid[7:0], sid[15:8]};
  endfunction

  function automatic logic [31:0] pack_seq(input logic [31:0] seq);
    return {seq[7:0], seq[15:8], seq[23:16], seq[31:24]};
  endfunction

endpackage

// File: rtl/seq_table.sv
// rtl/seq_table.sv - per-stream 32-bit sequence register file with read+1 lookahead
module seq_table #(
  parameter int NUM_STREAMS = 32,
  parameter int ADDR_W      = $clog2(NUM_STREAMS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  output logic [31:0]       nextSeq,
  input  logic              wrEn,
  input  logic [31:0]       wrData
);

  logic [31:0] seqMem [NUM_STREAMS];
  logic [31:0] rdData;

  assign rdData  = seqMem[addr];
  assign nextSeq = rdData + 32'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_STREAMS; i++) begin
        seqMem[i] <= '0;
      end
    end else if (wrEn) begin
      seqMem[addr] <= wrData;
    end
  end

endmodule

// File: rtl/packetizer.sv
// rtl/packetizer.sv - frames one payload per handshake into header, sequence and data words
module packetizer #(
  parameter int NUM_STREAMS       = 32,
  parameter int MAX_PAYLOAD_BYTES = 37
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [0:8*MAX_PAYLOAD_BYTES-1] payload_in,
  input  logic [5:0]                     payload_len,
  input  logic [15:0]                    stream_id,
  input  logic                           payload_val,
  output logic                           payload_ready,
  output logic [31:0]                    dataOut,
  output logic                           dataOut_val,
  input  logic                           dataOut_ready,
  output logic                           dataOut_last,
  output logic                           err_len
);

  import parser_pkg::*;

  localparam int TBL_W     = $clog2(NUM_STREAMS);
  localparam int MAX_WORDS = (MAX_PAYLOAD_BYTES + 3) / 4;
  localparam int PAD_BITS  = 32 * MAX_WORDS - 8 * MAX_PAYLOAD_BYTES;
  localparam int IDX_W     = $clog2(MAX_WORDS);

  state_t state, stateNext;

  logic [0:32*MAX_WORDS-1] payloadReg;
  logic [5:0]              lenReg;
  logic [15:0]             sidReg;
  logic [31:0]             seqReg;
  logic [IDX_W-1:0]        wordIdx;
  logic [IDX_W+1:0]        wordEnd;
  logic [31:0]             nextSeq;
  logic [31:0]             dataWord;
  logic [31:0]             lastMask;
  logic [15:0]             totalLen;
  logic                    accept, lenOk, isLast;

  assign accept   = payload_val && payload_ready;
  assign lenOk    = (payload_len != 6'd0) && (payload_len <= 6'(MAX_PAYLOAD_BYTES));
  assign totalLen = {10'd0, lenReg} + 16'(HDR_BYTES);
  assign dataWord = payloadReg[{wordIdx, 5'b00000} +: 32];
  assign wordEnd  = {wordIdx, 2'b00} + (IDX_W+2)'(4);
  assign isLast   = wordEnd >= (IDX_W+2)'(lenReg);

  seq_table #(
    .NUM_STREAMS (NUM_STREAMS)
  ) u_seq_table (
    .clk     (clk),
    .reset   (reset),
    .addr    (stream_id[TBL_W-1:0]),
    .nextSeq (nextSeq),
    .wrEn    (accept && lenOk),
    .wrData  (nextSeq)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      payload_ready <= 1'b1;
      err_len       <= 1'b0;
      payloadReg    <= '0;
      lenReg        <= '0;
      sidReg        <= '0;
      seqReg        <= '0;
      wordIdx       <= '0;
    end else begin
      state         <= stateNext;
      payload_ready <= (stateNext == IDLE);
      err_len       <= accept && !lenOk;
      if (accept && lenOk) begin
        payloadReg <= {payload_in, {PAD_BITS{1'b0}}};
        lenReg     <= payload_len;
        sidReg     <= stream_id;
        seqReg     <= nextSeq;
        wordIdx    <= '0;
      end else if (state == DATA && dataOut_ready) begin
        wordIdx <= wordIdx + 1'b1;
      end
    end
  end

  // Only the final word is trimmed; bytes past payload_len may carry source junk.
  always_comb begin
    lastMask = '1;
    if (isLast) begin
      case (lenReg[1:0])
        2'd1:    lastMask = 32'hFF00_0000;
        2'd2:    lastMask = 32'hFFFF_0000;
        2'd3:    lastMask = 32'hFFFF_FF00;
        default: lastMask = '1;
      endcase
    end
  end

  always_comb begin
    stateNext    = state;
    dataOut      = '0;
    dataOut_val  = 1'b0;
    dataOut_last = 1'b0;
    case (state)
      IDLE: begin
        if (accept && lenOk) stateNext = HDR0;
      end
      HDR0: begin
        dataOut_val = 1'b1;
        dataOut     = pack_hdr0(totalLen, sidReg);
        if (dataOut_ready) stateNext = HDR1;
      end
      HDR1: begin
        dataOut_val = 1'b1;
        dataOut     = pack_seq(seqReg);
        if (dataOut_ready) stateNext = DATA;
      end
      DATA: begin
        dataOut_val  = 1'b1;
        dataOut      = dataWord & lastMask;
        dataOut_last = isLast;
        if (dataOut_ready && isLast) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule
